// File: rtl/gpg_spi_pkg.sv
// Shared types and GoPiGo3 constants for the SPI command sequencer.
// The sequencer states are listed in order; leds shows them one-hot in this order.
package gpg_spi_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_SEND    = 3'd3,
        ST_ACK     = 3'd4,
        ST_XFER    = 3'd5,
        ST_HOLD    = 3'd6
    } seq_state_e;

    localparam logic [7:0] GPG_ADDR     = 8'h08;
    localparam logic [7:0] MSG_SET_LED  = 8'h06;
    localparam logic [7:0] LED_EYE_BOTH = 8'h03;

    function automatic logic [7:0] state_onehot(input seq_state_e s);
        logic [7:0] r;
        r    = 8'h00;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/gpg_spi_clkdiv.sv
// Bit-rate enable generator for the byte-level SPI master plus the busy filter
// that lets a falling busy_spi count only on an enable cycle.
module gpg_spi_clkdiv #(
    parameter int CLK_DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy_spi,
    output logic ena_2clk,
    output logic busy_filt
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ena_q, ena_d;
    logic          busy_q, busy_d;

    always_comb begin
        ena_d  = (cnt_q == CNT_LAST);
        cnt_d  = (start || ena_d) ? '0 : cnt_q + CW'(1);
        busy_d = busy_q;
        // Rising busy is taken at once; the master only drops busy in step with the enable.
        if (busy_spi) begin
            busy_d = 1'b1;
        end else if (ena_q) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            ena_q  <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            ena_q  <= ena_d;
            busy_q <= busy_d;
        end
    end

    assign ena_2clk  = ena_q;
    assign busy_filt = busy_q;

endmodule

// File: rtl/gpg_spi_seq.sv
// SPI command sequencer: takes an N-byte message, frames it with SSBar setup/hold
// and feeds it byte by byte to the SPI master. MISO capture is built only with GPG_SPI_SEQ_RX_EN.
module gpg_spi_seq
    import gpg_spi_pkg::*;
#(
    parameter int CLK_DIV      = 12,
    parameter int MAX_BYTES    = 8,
    parameter int LEN_W        = 4,
    parameter int STARTUP_CYC  = 500,
    parameter int SS_SETUP_CYC = 64,
    parameter int SS_HOLD_CYC  = 16,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    input  logic                   busy_spi,
    input  logic [7:0]             spi_rx_data,
    output logic                   ena_2clk,
    output logic                   start,
    output logic [7:0]             data_spi,
    output logic                   SSBar,
    output logic                   done,
    output logic                   err,
    output logic [8*MAX_BYTES-1:0] rx_data,
    output logic [7:0]             leds
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [31:0]      STARTUP_LAST = 32'(STARTUP_CYC - 1);
    localparam logic [31:0]      SETUP_LAST   = 32'(SS_SETUP_CYC - 1);
    localparam logic [31:0]      HOLD_LAST    = 32'(SS_HOLD_CYC - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W-1:0] LEN_MAX      = LEN_W'(MAX_BYTES);

    // Handshake: a command is taken on a clock edge where cmd_valid and cmd_ready are both high;
    // cmd_ready is high only in IDLE and never in the cycle done is high.

    seq_state_e             state_q, state_d;
    logic [31:0]            cyc_q, cyc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic                   tmo_q, tmo_d;
    logic                   err_q, err_d;
    logic                   start_q, start_d;
    logic                   done_q, done_d;
    logic                   ssbar_q, ssbar_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic [7:0]             data_spi_q, data_spi_d;
    logic [7:0]             leds_q, leds_d;

    logic busy_filt;
    logic start_now;
    logic done_now;
    logic capture;
    logic last_byte;

    gpg_spi_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk       (clk),
        .rst       (rst),
        .start     (start_q),
        .busy_spi  (busy_spi),
        .ena_2clk  (ena_2clk),
        .busy_filt (busy_filt)
    );

    assign last_byte = (LEN_W'(idx_q) == len_q - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STARTUP;
            cyc_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            tmo_q       <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            ssbar_q     <= 1'b1;
            cmd_ready_q <= 1'b0;
            data_spi_q  <= '0;
            leds_q      <= 8'h01;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            data_q      <= data_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            start_q     <= start_d;
            done_q      <= done_d;
            ssbar_q     <= ssbar_d;
            cmd_ready_q <= cmd_ready_d;
            data_spi_q  <= data_spi_d;
            leds_q      <= leds_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q + 32'd1;
        idx_d     = idx_q;
        len_d     = len_q;
        data_d    = data_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        start_now = 1'b0;
        done_now  = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            ST_STARTUP: begin
                if (cyc_q == STARTUP_LAST) begin
                    state_d = ST_IDLE;
                    cyc_d   = '0;
                end
            end
            ST_IDLE: begin
                cyc_d = '0;
                if (cmd_valid && cmd_ready_q) begin
                    len_d  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                    data_d = cmd_data;
                    idx_d  = '0;
                    tmo_d  = 1'b0;
                    err_d  = 1'b0;
                    if (cmd_len == '0) begin
                        done_now = 1'b0 | 1'b1;
                    end else begin
                        // The accept cycle counts as the first setup clock, so the first
                        // start lands exactly SS_SETUP_CYC clocks after SSBar falls.
                        state_d = ST_SETUP;
                        cyc_d   = 32'd1;
                    end
                end
            end
            ST_SETUP: begin
                if (cyc_q >= SETUP_LAST) begin
                    state_d = ST_SEND;
                    cyc_d   = '0;
                end
            end
            ST_SEND: begin
                cyc_d = '0;
                if (!busy_filt) begin
                    start_now = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (busy_filt) begin
                    state_d = ST_XFER;
                    cyc_d   = '0;
                end else if (cyc_q == TIMEOUT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_HOLD;
                    cyc_d   = '0;
                end
            end
            ST_XFER: begin
                cyc_d = '0;
                if (!busy_filt) begin
                    capture = 1'b1;
                    if (last_byte) begin
                        // Two clocks already passed since busy_spi fell (filter + this decision).
                        state_d = ST_HOLD;
                        cyc_d   = 32'd2;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_HOLD: begin
                if (cyc_q >= HOLD_LAST) begin
                    state_d  = ST_IDLE;
                    cyc_d    = '0;
                    done_now = 1'b1;
                    err_d    = tmo_q;
                end
            end
            default: begin
                state_d = ST_STARTUP;
                cyc_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        start_d     = start_now;
        done_d      = done_now;
        cmd_ready_d = (state_d == ST_IDLE) && !done_now;
        ssbar_d     = (state_d == ST_IDLE) || (state_d == ST_STARTUP);
        data_spi_d  = data_spi_q;
        if (state_d == ST_SEND) begin
            data_spi_d = data_d[{idx_d, 3'b000} +: 8];
        end
        leds_d      = state_onehot(state_d);
    end

`ifdef GPG_SPI_SEQ_RX_EN
    logic [8*MAX_BYTES-1:0] rx_q, rx_d;

    always_comb begin
        rx_d = rx_q;
        if (capture) begin
            rx_d[{idx_q, 3'b000} +: 8] = spi_rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q <= '0;
        end else begin
            rx_q <= rx_d;
        end
    end

    assign rx_data = rx_q;
`else
    logic rx_unused;
    assign rx_unused = ^{spi_rx_data, capture};
    assign rx_data   = '0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign start     = start_q;
    assign data_spi  = data_spi_q;
    assign SSBar     = ssbar_q;
    assign done      = done_q;
    assign err       = err_q;
    assign leds      = leds_q;

endmodule
